// File: rtl/coproc_arbiter.sv
// Two-port round-robin arbiter and sequencer for the mul/div/shift coprocessor.
// Grants one requester, runs trigger/poll/readback on the sel/go bus, returns results with a one-cycle ack.
module coproc_arbiter #(
    parameter int WIDTH = 16,
    parameter int TMO   = 255
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [1:0]       fmt0,
    input  logic [1:0]       fmt1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_ovf,
    output logic             res_err,
    output logic [10:0]      cp_sel,
    output logic             cp_go,
    output logic [WIDTH-1:0] cp_a,
    output logic [WIDTH-1:0] cp_b,
    output logic [WIDTH-1:0] cp_c,
    input  logic [WIDTH-1:0] cp_y
);

    localparam int            CW      = $clog2(TMO + 2);
    localparam logic [CW-1:0] TMO_C   = CW'(TMO);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_TRIG, S_GAP, S_POLL, S_WAIT, S_RHI, S_RLO, S_RCAP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic             any_req;
    logic             pick;
    logic [1:0]       pick_op;
    logic             pick_rsvd;
    logic             busy;
    logic             timeout;

    // On a tie the pointer side wins; a lone requester always wins.
    assign any_req   = req0 | req1;
    assign pick      = (req0 & req1) ? ptr_q : req1;
    assign pick_op   = pick ? op1 : op0;
    assign pick_rsvd = (pick_op == 2'b11);
    assign busy      = cp_y[0];
    assign timeout   = (cnt_q == TMO_C);

    function automatic logic [3:0] trig_code(input logic [1:0] op);
        case (op)
            2'b00:   trig_code = 4'h8;
            2'b01:   trig_code = 4'h9;
            default: trig_code = 4'hA;
        endcase
    endfunction

    function automatic logic [3:0] hi_code(input logic [1:0] op);
        case (op)
            2'b00:   hi_code = 4'h2;
            2'b01:   hi_code = 4'h4;
            default: hi_code = 4'h6;
        endcase
    endfunction

    function automatic logic [3:0] lo_code(input logic [1:0] op);
        case (op)
            2'b00:   lo_code = 4'h3;
            2'b01:   lo_code = 4'h5;
            default: lo_code = 4'h7;
        endcase
    endfunction

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = pick_rsvd ? S_DONE : S_TRIG;
                end
            end
            S_TRIG: state_d = S_GAP;
            S_GAP:  state_d = S_POLL;
            S_POLL: state_d = S_WAIT;
            S_WAIT: begin
                if (!busy) begin
                    state_d = S_RHI;
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_RHI:  state_d = S_RLO;
            S_RLO:  state_d = S_RCAP;
            S_RCAP: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes depend on the live busy bit in WAIT, so they stay combinational.
    always_comb begin
        cp_go  = 1'b0;
        cp_sel = '0;
        case (state_q)
            S_TRIG: begin
                cp_go       = 1'b1;
                cp_sel[3:0] = trig_code(op_q);
                if (op_q == 2'b10) begin
                    cp_sel[7:6] = fmt_q;
                end
            end
            S_POLL: cp_go = 1'b1;
            S_WAIT: begin
                if (!busy) begin
                    cp_go       = 1'b1;
                    cp_sel[3:0] = 4'h1;
                end else if (!timeout) begin
                    cp_go = 1'b1;
                end
            end
            S_RHI: begin
                cp_go       = 1'b1;
                cp_sel[3:0] = hi_code(op_q);
            end
            S_RLO: begin
                cp_go       = 1'b1;
                cp_sel[3:0] = lo_code(op_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        gnt_d  = gnt_q;
        op_d   = op_q;
        fmt_d  = fmt_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d = pick;
                    if (req0 & req1) begin
                        ptr_d = ~ptr_q;
                    end
                    op_d  = pick_op;
                    fmt_d = pick ? fmt1 : fmt0;
                    a_d   = pick ? a1 : a0;
                    b_d   = pick ? b1 : b0;
                    c_d   = pick ? c1 : c0;
                    hi_d  = '0;
                    lo_d  = '0;
                    ovf_d = 1'b0;
                    err_d = pick_rsvd;
                    if (pick_rsvd) begin
                        ack0_d = ~pick;
                        ack1_d = pick;
                    end
                end
            end
            S_POLL: cnt_d = '0;
            S_WAIT: begin
                if (busy) begin
                    if (timeout) begin
                        err_d  = 1'b1;
                        hi_d   = '0;
                        lo_d   = '0;
                        ovf_d  = 1'b0;
                        ack0_d = ~gnt_q;
                        ack1_d = gnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_RHI:  ovf_d = (op_q == 2'b01) & cp_y[8];
            S_RLO:  hi_d  = cp_y;
            S_RCAP: begin
                lo_d   = cp_y;
                ack0_d = ~gnt_q;
                ack1_d = gnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr_q  <= 1'b0;
            gnt_q  <= 1'b0;
            op_q   <= '0;
            fmt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            op_q   <= op_d;
            fmt_q  <= fmt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            ack0_q <= ack0_d;
            ack1_q <= ack1_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign res_hi  = hi_q;
    assign res_lo  = lo_q;
    assign res_ovf = ovf_q;
    assign res_err = err_q;
    assign cp_a    = a_q;
    assign cp_b    = b_q;
    assign cp_c    = c_q;

endmodule
